guv_cmd_sequencer: RTL
======================

Name: guv_cmd_sequencer

Overview:
- Arbitrates N command sources (host link, trigger unit, self-test) onto the single 29-bit cmd_in_TDATA port of control_FSM.
- Holds each command for its requested duration or until its matching done_DONE_* pulse arrives.
- Then drives the release word (CONT_EN=0, op bits kept) until control_FSM reports done_START, then idles for a gap before the next grant.
- Sits between the command sources and control_FSM/datapath inside dbg_guv.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- HOLD_W, 16, width of per-request hold count.
- GAP_CYCLES, 2, cycles of all-zero command between commands (>=1).
- TIMEOUT_CYCLES, 1024, completion wait limit in ISSUE(hold=0) and RELEASE (only used with GUV_SEQ_TIMEOUT_EN).

Ports:
- CLOCK_50  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester command valid.
- req_cmd  in  N_REQ*29  flattened command words, requester i at [29*i+:29].
- req_hold  in  N_REQ*HOLD_W  flattened hold counts (0 = complete on done pulse).
- req_ready  out  N_REQ  one-hot accept strobe.
- done_START, done_DONE_DROP, done_DONE_INJECT, done_DONE_LOG, done_DONE_PAUSE  in  1 each  completion pulses from datapath.
- abort  in  1  force release of the in-flight command.
- err_clr  in  1  clears sticky errors.
- cmd_out_TDATA  out  29  drives control_FSM cmd_in_TDATA.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(N_REQ) (min 1)  index of the in-flight requester.
- err_badcmd  out  1  sticky; illegal op field accepted.
- err_timeout  out  1  sticky; completion wait expired.

Behaviour:
- Command word: bit0 CONT_EN, bit1 PAUSE, bit2 reserved-0, bit3 DROP_RDATA, bit4 DROP_WDATA, bit5 INJ_RDATA, bit6 INJ_WDATA, bit7 LOG, [28:8] operand.
- Legal op field [7:1]: exactly one bit set, with bit2=0.
- Reset (async, any state): state=IDLE; all outputs 0; RR pointer=N_REQ-1 so requester 0 has first priority; latched command, counters and errors cleared.
- IDLE: cmd_out=0. With any req_valid, the round-robin grant goes to the first valid index after the pointer.
  - req_ready[g] is asserted combinationally that same cycle, and the command and hold are latched.
  - The pointer becomes g.
  - Legal op -> ISSUE next cycle.
  - Illegal op -> still accepted; err_badcmd set; -> GAP.
- ISSUE: cmd_out = latched cmd with bit0 forced 1. First driven cycle is 1 cycle after acceptance.
  - hold>0: driven exactly hold cycles -> RELEASE; done pulses ignored.
  - hold=0: -> RELEASE on the cycle after the matching done pulse.
  - Matching done: DROP_*->done_DONE_DROP, INJ_*->done_DONE_INJECT, LOG->done_DONE_LOG, PAUSE->done_DONE_PAUSE.
- RELEASE: cmd_out = latched cmd with bit0=0. Stays until done_START is sampled high, then -> GAP.
- GAP: cmd_out=0 for GAP_CYCLES -> IDLE. A new grant is possible on the first IDLE cycle.
- abort: in ISSUE -> RELEASE next cycle. Ignored in IDLE, RELEASE and GAP.
- Simultaneous events:
  - abort with matching done in ISSUE -> RELEASE (single transition).
  - done with timeout expiry in the same cycle -> done wins; no error.
  - err_clr with a new error in the same cycle -> error wins (stays set).
- Hold counter is HOLD_W bits and counts down from hold. The hold=2^HOLD_W-1 maximum must not wrap.
- A requester dropping req_valid before its grant is legal; there is no AXI stickiness requirement.

Optional Feature:
- Macro: GUV_SEQ_TIMEOUT_EN.
- When defined: a 32-bit wait counter runs in ISSUE(hold=0) and RELEASE and resets on each state entry.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set and state -> GAP with cmd_out=0.
- When undefined: no counter is generated; the block waits indefinitely; err_timeout is tied 0.

Decomposition:
- Package guv_cmd_pkg holds:
  - CMD_W=29 and the bit-index localparams.
  - Typedef seq_state_t {IDLE, ISSUE, RELEASE, GAP}.
  - Function op_legal(cmd).
  - Function op_done_sel(cmd, done vector).
  - control_FSM and datapath import the same field constants.
- One sub-module: guv_rr_arbiter (N-way round-robin with pointer update on accept), reused later for log-channel sharing.

Test Plan:
- Reset; req0 valid, cmd=0x009 (DROP_RDATA), hold=0 -> req_ready[0] same cycle; cmd_out=0x009 next cycle.
  - Pulse done_DONE_DROP -> cmd_out=0x008 next cycle.
  - Pulse done_START -> 0x000 for 2 cycles; busy falls.
- req0 and req1 both valid continuously -> grants alternate 0,1,0,1; grant_id matches; no requester is granted twice in a row.
- req1 cmd=0x003 (PAUSE), hold=5 -> cmd_out=0x003 for exactly 5 cycles, then 0x002 until done_START.
- req0 cmd=0x019 (two op bits) -> accepted; err_badcmd=1; cmd_out stays 0; err_clr clears it.
- With GUV_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: cmd=0x021, hold=0, no done -> err_timeout set after 16 cycles; state GAP; next request is served.
- Deassert rst_n in ISSUE -> cmd_out=0 and busy=0 immediately (asynchronously); after release, requester 0 has priority.

Source files
------------

// File: rtl/guv_cmd_pkg.sv
// guv_cmd_pkg: command word layout, sequencer states and op-field helpers shared by
// the sequencer, control_FSM and datapath.
package guv_cmd_pkg;

   localparam int CMD_W        = 29;
   localparam int B_CONT_EN    = 0;
   localparam int B_PAUSE      = 1;
   localparam int B_RSVD       = 2;
   localparam int B_DROP_RDATA = 3;
   localparam int B_DROP_WDATA = 4;
   localparam int B_INJ_RDATA  = 5;
   localparam int B_INJ_WDATA  = 6;
   localparam int B_LOG        = 7;
   localparam int B_OPND       = 8;

   // Positions inside the packed completion-pulse vector handed to op_done_sel.
   localparam int D_DROP   = 0;
   localparam int D_INJECT = 1;
   localparam int D_LOG    = 2;
   localparam int D_PAUSE  = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, GAP} seq_state_t;

   // A legal op field has exactly one bit set among [7:1], and that bit is not the reserved bit.
   function automatic logic op_legal(input logic [CMD_W-1:0] cmd);
      logic [6:0] op;
      op = cmd[B_LOG:B_PAUSE];
      return !cmd[B_RSVD] && (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
   endfunction

   // High when the completion pulse that belongs to this command's op is present.
   function automatic logic op_done_sel(input logic [CMD_W-1:0] cmd, input logic [3:0] done);
      return ((cmd[B_DROP_RDATA] | cmd[B_DROP_WDATA]) & done[D_DROP])
           | ((cmd[B_INJ_RDATA]  | cmd[B_INJ_WDATA])  & done[D_INJECT])
           | (cmd[B_LOG]   & done[D_LOG])
           | (cmd[B_PAUSE] & done[D_PAUSE]);
   endfunction

endpackage

// File: rtl/guv_rr_arbiter.sv
// guv_rr_arbiter: N-way round-robin arbiter; the pointer moves to the winner on accept.
module guv_rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  req_i,
   input  logic          accept_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_id_o,
   output logic          valid_o
);

   logic [IW-1:0] ptr_q, ptr_d;

   // Search starts one past the pointer so the last winner has the lowest priority.
   always_comb begin
      valid_o  = 1'b0;
      gnt_id_o = ptr_q;
      for (int i = 1; i <= N; i++) begin
         if (!valid_o && req_i[(int'(ptr_q) + i) % N]) begin
            valid_o  = 1'b1;
            gnt_id_o = IW'((int'(ptr_q) + i) % N);
         end
      end
      gnt_o = valid_o ? (N'(1) << gnt_id_o) : '0;
      ptr_d = (accept_i && valid_o) ? gnt_id_o : ptr_q;
   end

   // Pointer starts at N-1 so requester 0 wins first after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= IW'(N - 1);
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/guv_cmd_sequencer.sv
// guv_cmd_sequencer: round-robin command sequencer in front of control_FSM.
// Optional macro GUV_SEQ_TIMEOUT_EN adds a completion-wait timeout (err_timeout).
module guv_cmd_sequencer
   import guv_cmd_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int HOLD_W         = 16,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                     CLOCK_50,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*CMD_W-1:0]   req_cmd,
   input  logic [N_REQ*HOLD_W-1:0]  req_hold,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     done_START,
   input  logic                     done_DONE_DROP,
   input  logic                     done_DONE_INJECT,
   input  logic                     done_DONE_LOG,
   input  logic                     done_DONE_PAUSE,
   input  logic                     abort,
   input  logic                     err_clr,
   output logic [CMD_W-1:0]         cmd_out_TDATA,
   output logic                     busy,
   output logic [GW-1:0]            grant_id,
   output logic                     err_badcmd,
   output logic                     err_timeout
);

   localparam int GCW = $clog2(GAP_CYCLES + 1);

   if (N_REQ < 1 || N_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("guv_cmd_sequencer: parameter out of range");
   end

   seq_state_t        state_q, state_d;
   logic [CMD_W-1:1]  cmd_q, cmd_d;
   logic [HOLD_W-1:0] hcnt_q, hcnt_d;
   logic [GCW-1:0]    gcnt_q, gcnt_d;
   logic [GW-1:0]     gid_q, gid_d;
   logic              bad_q, bad_d, bad_set;
   logic              tmo_set;
   logic [N_REQ-1:0]  arb_gnt;
   logic [GW-1:0]     arb_id;
   logic              arb_valid;
   logic [CMD_W-1:0]  cmd_sel;
   logic              done_hit;

   guv_rr_arbiter #(.N(N_REQ), .IW(GW)) u_arb (
      .clk_i    (CLOCK_50),
      .rst_ni   (rst_n),
      .req_i    (req_valid),
      .accept_i (state_q == IDLE),
      .gnt_o    (arb_gnt),
      .gnt_id_o (arb_id),
      .valid_o  (arb_valid)
   );

   assign cmd_sel  = req_cmd[arb_id*CMD_W +: CMD_W];
   assign done_hit = op_done_sel({cmd_q, 1'b0},
                                 {done_DONE_PAUSE, done_DONE_LOG, done_DONE_INJECT, done_DONE_DROP});

`ifdef GUV_SEQ_TIMEOUT_EN
   logic [31:0] wcnt_q, wcnt_d;
   logic        tmo_hit, tmo_q, tmo_d;
   logic        waiting;

   assign waiting = (state_q == RELEASE) || (state_q == ISSUE && hcnt_q == '0);
   assign tmo_hit = waiting && (wcnt_q == 32'(TIMEOUT_CYCLES - 1));

   // Wait counter restarts on every state change and only advances while waiting for completion.
   always_comb begin
      wcnt_d = (waiting && state_d == state_q) ? wcnt_q + 32'd1 : 32'd0;
      tmo_d  = tmo_set | (tmo_q & ~err_clr);
   end

   // Timeout counter and sticky timeout error.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         tmo_q  <= tmo_d;
      end
   end

   assign err_timeout = tmo_q;
`else
   assign err_timeout = 1'b0;
`endif

   // Next-state logic: grant/latch in IDLE, hold or wait for done in ISSUE, wait for START in RELEASE.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      hcnt_d  = hcnt_q;
      gid_d   = gid_q;
      bad_set = 1'b0;
      tmo_set = 1'b0;
      gcnt_d  = (state_q == GAP) ? gcnt_q + GCW'(1) : '0;
      case (state_q)
         IDLE: if (arb_valid) begin
            cmd_d   = cmd_sel[CMD_W-1:1];
            hcnt_d  = req_hold[arb_id*HOLD_W +: HOLD_W];
            gid_d   = arb_id;
            bad_set = !op_legal(cmd_sel);
            state_d = op_legal(cmd_sel) ? ISSUE : GAP;
         end
         ISSUE: begin
            hcnt_d = (hcnt_q > HOLD_W'(1)) ? hcnt_q - HOLD_W'(1) : hcnt_q;
            if (abort || hcnt_q == HOLD_W'(1) || (hcnt_q == '0 && done_hit)) state_d = RELEASE;
`ifdef GUV_SEQ_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = GAP;
               tmo_set = 1'b1;
            end
`endif
         end
         RELEASE: begin
            if (done_START) state_d = GAP;
`ifdef GUV_SEQ_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = GAP;
               tmo_set = 1'b1;
            end
`endif
         end
         default: if (gcnt_q == GCW'(GAP_CYCLES - 1)) state_d = IDLE;
      endcase
      bad_d = bad_set | (bad_q & ~err_clr);
   end

   // Sequencer state, latched command and counters.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         hcnt_q  <= '0;
         gcnt_q  <= '0;
         gid_q   <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         hcnt_q  <= hcnt_d;
         gcnt_q  <= gcnt_d;
         gid_q   <= gid_d;
         bad_q   <= bad_d;
      end
   end

   assign req_ready     = (state_q == IDLE) ? arb_gnt : '0;
   assign cmd_out_TDATA = (state_q == ISSUE)   ? {cmd_q, 1'b1} :
                          (state_q == RELEASE) ? {cmd_q, 1'b0} : '0;
   assign busy          = (state_q != IDLE);
   assign grant_id      = gid_q;
   assign err_badcmd    = bad_q;

endmodule
